// File: rtl/audio_clip_sequencer.sv
// audio_clip_sequencer: plays one of four fixed clips from the sound ROM into
// the codec FIFO at one sample every DIV clocks, with start/stop/loop/done
// control and a saturating count of samples dropped for lack of FIFO space.
// Optional build macro AUDIO_SEQ_QUEUE_EN adds a one-deep pending play request
// that starts directly when the current clip ends.
module audio_clip_sequencer #(
  parameter int ADDR_W   = 18,
  parameter int SAMPLE_W = 6,
  parameter int DIV      = 1200
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                play_req,
  input  logic [1:0]          clip_sel,
  input  logic                loop_en,
  input  logic                stop,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_q,
  input  logic                audio_out_allowed,
  output logic                write_audio_out,
  output logic [31:0]         left_channel_audio_out,
  output logic [31:0]         right_channel_audio_out,
  output logic                busy,
  output logic                clip_done,
  output logic [15:0]         underrun_count
);

  // DIV is at most 2047, so 11 bits always hold the sample-period count.
  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_WAIT
  } state_t;

  // First ROM address of each clip.
  function automatic logic [ADDR_W-1:0] clip_start(input logic [1:0] id);
    logic [ADDR_W-1:0] a;
    case (id)
      2'd0:    a = ADDR_W'(0);
      2'd1:    a = ADDR_W'(16396);
      2'd2:    a = ADDR_W'(66983);
      default: a = ADDR_W'(83255);
    endcase
    return a;
  endfunction

  // Last ROM address of each clip (inclusive).
  function automatic logic [ADDR_W-1:0] clip_end(input logic [1:0] id);
    logic [ADDR_W-1:0] a;
    case (id)
      2'd0:    a = ADDR_W'(16395);
      2'd1:    a = ADDR_W'(66982);
      2'd2:    a = ADDR_W'(83254);
      default: a = ADDR_W'(137138);
    endcase
    return a;
  endfunction

  // Underrun counter sticks at all-ones rather than wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         under_q, under_d;
  logic                tick;
`ifdef AUDIO_SEQ_QUEUE_EN
  logic                pend_vld_q, pend_vld_d;
  logic [1:0]          pend_sel_q, pend_sel_d;
`endif

  assign tick = (cnt_q == CNT_LAST);

  // Next-state logic: clip walking, sample timing, write/drop decision, stop.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    start_d  = start_q;
    end_d    = end_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    data_d   = data_q;
    wr_d     = 1'b0;
    done_d   = 1'b0;
    under_d  = under_q;
`ifdef AUDIO_SEQ_QUEUE_EN
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;
`endif

    // The period counter free-runs while active so address wraps never
    // stretch the sample period.
    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

`ifdef AUDIO_SEQ_QUEUE_EN
    // A request while playing is parked; a newer one replaces an older one.
    if ((state_q != S_IDLE) && play_req) begin
      pend_vld_d = 1'b1;
      pend_sel_d = clip_sel;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (play_req) begin
          start_d = clip_start(clip_sel);
          end_d   = clip_end(clip_sel);
          addr_d  = clip_start(clip_sel);
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // ROM data for addr_q becomes valid next cycle.
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        sample_d = rom_q;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (tick) begin
          if (audio_out_allowed) begin
            wr_d   = 1'b1;
            data_d = sample_q;
          end else begin
            under_d = sat_inc(under_q);
          end

          if (addr_q != end_q) begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
`ifdef AUDIO_SEQ_QUEUE_EN
          end else if (pend_vld_d) begin
            // Queued clip starts as if accepted in this cycle; loop_en only
            // decides whether the ending clip reports completion.
            start_d    = clip_start(pend_sel_d);
            end_d      = clip_end(pend_sel_d);
            addr_d     = clip_start(pend_sel_d);
            cnt_d      = '0;
            pend_vld_d = 1'b0;
            done_d     = ~loop_en;
            state_d    = S_FETCH;
`endif
          end else if (loop_en) begin
            addr_d  = start_q;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any same-cycle tick or request.
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      start_d = start_q;
      end_d   = end_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      wr_d    = 1'b0;
      done_d  = 1'b0;
      under_d = under_q;
`ifdef AUDIO_SEQ_QUEUE_EN
      pend_vld_d = 1'b0;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      under_q <= '0;
`ifdef AUDIO_SEQ_QUEUE_EN
      pend_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      under_q <= under_d;
`ifdef AUDIO_SEQ_QUEUE_EN
      pend_vld_q <= pend_vld_d;
`endif
    end
  end

  // Clip bounds and captured sample are only read once loaded, so no reset.
  always_ff @(posedge CLOCK_50) begin
    start_q  <= start_d;
    end_q    <= end_d;
    sample_q <= sample_d;
`ifdef AUDIO_SEQ_QUEUE_EN
    pend_sel_q <= pend_sel_d;
`endif
  end

  assign rom_addr                = addr_q;
  assign write_audio_out         = wr_q;
  assign left_channel_audio_out  = {data_q, {(32-SAMPLE_W){1'b0}}};
  assign right_channel_audio_out = {data_q, {(32-SAMPLE_W){1'b0}}};
  assign busy                    = busy_q;
  assign clip_done               = done_q;
  assign underrun_count          = under_q;

endmodule
